// File: rtl/apb_regfile_completer.sv
// apb_regfile_completer: APB completer with a bank of byte-strobed registers
// and a fixed number of wait states per transfer.
// Build option: define APB_COMPLETER_SLVERR_EN to build the out-of-range error
// response (PSLVERR=1, reads return 0, writes dropped). Without it, PSLVERR is
// tied low and out-of-range addresses alias onto PADDR mod RegCount.

// One register of the bank; each byte lane updates only when its strobe is set.
module apb_regfile_reg #(
  parameter int DataWidth = 32,
  parameter int StrbWidth = DataWidth / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [StrbWidth-1:0] strb,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] q
);
  for (genvar b = 0; b < StrbWidth; b++) begin : g_lane
    // Byte lane b: clear on reset, load when written with its strobe set.
    always_ff @(posedge clk) begin
      if (reset)                q[8*b +: 8] <= '0;
      else if (we && strb[b])   q[8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module apb_regfile_completer #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int RegCount   = 16,
  parameter int WaitStates = 2,
  parameter int StrbWidth  = DataWidth / 8
) (
  input  logic                 PCLK,
  input  logic                 reset,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [AddrWidth-1:0] PADDR,
  input  logic [DataWidth-1:0] PWDATA,
  input  logic [StrbWidth-1:0] PSTRB,
  output logic                 PREADY,
  output logic [DataWidth-1:0] PRDATA,
  output logic                 PSLVERR
);
  localparam int IdxW = $clog2(RegCount);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                             state;
  logic [3:0]                         cnt;
  logic [IdxW-1:0]                    idx_q;
  logic                               write_q;
  logic [DataWidth-1:0]               wdata_q;
  logic [StrbWidth-1:0]               strb_q;
  logic [DataWidth-1:0]               rdata_q;
  logic                               err_q;
  logic [RegCount-1:0][DataWidth-1:0] regs;

  logic            setup;
  logic            done;
  logic            err_d;
  logic [IdxW-1:0] idx_d;

  assign setup = PSEL && !PENABLE;
  assign idx_d = PADDR[IdxW-1:0];
  // Completion needs PENABLE=1, so it can never coincide with a setup edge.
  assign done  = PREADY && PSEL && PENABLE;

`ifdef APB_COMPLETER_SLVERR_EN
  assign err_d = (PADDR >= AddrWidth'(RegCount));
  // Error flag of the transfer in flight, captured at setup.
  always_ff @(posedge PCLK) begin
    if (reset)      err_q <= 1'b0;
    else if (setup) err_q <= err_d;
  end
`else
  // Upper address bits only matter for the error check; aliasing ignores them.
  logic unused_addr_hi;
  assign unused_addr_hi = ^PADDR[AddrWidth-1:IdxW];
  assign err_d = 1'b0;
  assign err_q = 1'b0;
`endif

  // Transfer FSM: capture on setup, count wait states, complete or abort.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else if (setup) begin
      state   <= ACCESS;
      cnt     <= 4'(WaitStates);
      idx_q   <= idx_d;
      write_q <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
      rdata_q <= err_d ? '0 : regs[idx_d];
    end else if (state == ACCESS) begin
      if (!PSEL)                state <= IDLE;
      else if (cnt != 4'd0)     cnt   <= cnt - 4'd1;
      else                      state <= IDLE;
    end
  end

  for (genvar r = 0; r < RegCount; r++) begin : g_reg
    apb_regfile_reg #(.DataWidth(DataWidth), .StrbWidth(StrbWidth)) u_reg (
      .clk   (PCLK),
      .reset (reset),
      .we    (done && write_q && !err_q && (idx_q == IdxW'(r))),
      .strb  (strb_q),
      .wdata (wdata_q),
      .q     (regs[r])
    );
  end

  assign PREADY  = (state == ACCESS) && (cnt == 4'd0);
  assign PRDATA  = (PREADY && !write_q) ? rdata_q : '0;
  assign PSLVERR = PREADY && err_q;
endmodule
